// File: rtl/palette_loader_pkg.sv
// Shared brus16 types for the palette loader.
// PALETTE_LOADER_CLEAR_EN adds the post-reset CLEAR state.
package brus16_pkg;

  localparam int PAL_DEPTH = 64;
  localparam int PAL_AW    = 6;
  localparam int WORD_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
`ifdef PALETTE_LOADER_CLEAR_EN
    , CLEAR
`endif
  } ld_state_t;

endpackage

// File: rtl/palette_loader_if.sv
// Data-memory read port and palette BRAM write port A.
// master = loader, slave = arbiter/memory + BRAM side.
interface palette_loader_if #(
  parameter int MEM_AW = 16
);

  logic                         mem_re;
  logic [MEM_AW-1:0]            mem_addr;
  logic                         mem_grant;
  logic [brus16_pkg::WORD_W-1:0] mem_rdata;
  logic                         pal_cea;
  logic [brus16_pkg::PAL_AW-1:0] pal_ada;
  logic [brus16_pkg::WORD_W-1:0] pal_din;

  modport master (
    output mem_re, mem_addr,
    output pal_cea, pal_ada, pal_din,
    input  mem_grant, mem_rdata
  );

  modport slave (
    input  mem_re, mem_addr,
    input  pal_cea, pal_ada, pal_din,
    output mem_grant, mem_rdata
  );

endinterface

// File: rtl/palette_loader.sv
// Copies COUNT palette words from data memory into palette BRAM.
// PALETTE_LOADER_CLEAR_EN: zero the palette after reset.
module palette_loader
  import brus16_pkg::*;
#(
  parameter int COUNT  = PAL_DEPTH,
  parameter int MEM_AW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MEM_AW-1:0] base,
  output logic              busy,
  output logic              done,
  palette_loader_if.master  bus
);

  localparam logic [PAL_AW-1:0] LAST = PAL_AW'(COUNT - 1);

`ifdef PALETTE_LOADER_CLEAR_EN
  localparam ld_state_t RST_STATE = CLEAR;
`else
  localparam ld_state_t RST_STATE = IDLE;
`endif

  ld_state_t         state_q;
  ld_state_t         state_d;
  logic [MEM_AW-1:0] addr_q;
  logic [PAL_AW-1:0] rd_cnt;
  logic [PAL_AW-1:0] wr_cnt;
  logic [PAL_AW-1:0] ada_q;
  logic              cea_q;
  logic              accept;
  logic              last;
  logic              clr_wr;

  assign accept = (state_q == READ) && bus.mem_grant;
  assign last   = (rd_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) state_q <= RST_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = READ;
      READ:  if (accept && last) state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
`ifdef PALETTE_LOADER_CLEAR_EN
      CLEAR: if (last) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // rd_cnt doubles as the clear address while in CLEAR
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      ada_q  <= '0;
      cea_q  <= 1'b0;
    end else begin
      cea_q <= accept;
      if (accept) begin
        addr_q <= addr_q + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
        ada_q  <= wr_cnt;
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (state_q == IDLE && start) begin
        addr_q <= base;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end
`ifdef PALETTE_LOADER_CLEAR_EN
      if (state_q == CLEAR) rd_cnt <= rd_cnt + 1'b1;
`endif
    end
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    bus.mem_re = 1'b0;
    clr_wr     = 1'b0;
    unique case (state_q)
      READ: begin
        busy       = 1'b1;
        bus.mem_re = 1'b1;
      end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
`ifdef PALETTE_LOADER_CLEAR_EN
      CLEAR: begin
        busy   = 1'b1;
        clr_wr = !reset;
      end
`endif
      default: ;
    endcase
  end

  assign bus.mem_addr = addr_q;
  assign bus.pal_cea  = cea_q | clr_wr;
  assign bus.pal_ada  = clr_wr ? rd_cnt : ada_q;
  assign bus.pal_din  = (cea_q && !clr_wr) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_palette_loader.sv
// Scoreboard bench for palette_loader with randomized grant.
// Honours PALETTE_LOADER_CLEAR_EN when defined at build time.
module tb_palette_loader;

  typedef struct packed {
    logic [5:0]  ada;
    logic [15:0] din;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] base;
  logic        busy;
  logic        done;

  palette_loader_if #(.MEM_AW(16)) bus ();

  palette_loader #(
    .COUNT (64),
    .MEM_AW(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .base (base),
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  wr_t exp_q[$];
  int  done_q[$];
  int  cyc;
  int  busy_end;
  int  chk_hi;
  bit  chk_on;
  int  passes;
  int  total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: word at addr is addr ^ 0xA5A5, one-cycle latency
  always @(posedge clk) begin
    if (bus.mem_re && bus.mem_grant)
      bus.mem_rdata <= bus.mem_addr ^ 16'hA5A5;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h",
                  name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (bus.pal_cea === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL extra_write cyc=%0d ada=%0d din=%0h",
                 cyc, bus.pal_ada, bus.pal_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_ada", 32'(bus.pal_ada), 32'(e.ada));
        check("wr_din", 32'(bus.pal_din), 32'(e.din));
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        total++;
        $display("FAIL extra_done cyc=%0d", cyc);
      end else begin
        int ed;
        ed = done_q.pop_front();
        check("done_cycle", 32'(cyc), 32'(ed));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
    if (chk_on && cyc <= chk_hi)
      check("busy", 32'(busy), 32'(cyc >= 1 && cyc < busy_end));
  end

  task automatic push_clear();
    for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), 16'h0000});
  endtask

  task automatic wait_settle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_wr_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  // mode 0: grant high, 1: grant on odd cycles, 2: random grant
  // restart_at -2 means pulse start again during the done cycle
  task automatic run_xfer(input logic [15:0] b, input int mode,
                          input int restart_at, input int reset_at);
    bit g[512];
    int n;
    int ld;
    int rs;
    int c;
    n  = 0;
    ld = -1;
    for (int k = 0; k < 512; k++) begin
      if (k >= 400)       g[k] = 1'b1;
      else if (mode == 0) g[k] = 1'b1;
      else if (mode == 1) g[k] = (k % 2) == 1;
      else                g[k] = $urandom_range(0, 3) != 0;
    end
    for (int k = 1; k < 512 && n < 64; k++) begin
      if (g[k]) begin
        if (reset_at < 0 || k < reset_at) begin
          logic [15:0] a;
          a = b + 16'(n);
          exp_q.push_back({6'(n), a ^ 16'hA5A5});
        end
        n++;
        if (n == 64) ld = k;
      end
    end
    rs = (restart_at == -2) ? ld + 2 : restart_at;
    if (reset_at < 0) begin
      done_q.push_back(ld + 2);
      busy_end = ld + 2;
      chk_hi   = ld + 3;
    end else begin
      busy_end = reset_at + 1;
`ifdef PALETTE_LOADER_CLEAR_EN
      chk_hi = reset_at;
      push_clear();
`else
      chk_hi = reset_at + 3;
`endif
    end
    @(posedge clk);
    #1;
    cyc           = 0;
    start         = 1'b1;
    base          = b;
    bus.mem_grant = g[0];
    chk_on        = 1'b1;
    c = 1;
    while (c <= chk_hi + 1 && c < 512) begin
      @(posedge clk);
      #1;
      cyc           = c;
      start         = (c == rs);
      if (c == rs) base = ~b;
      bus.mem_grant = g[c];
      reset         = (c == reset_at);
      c++;
    end
    start  = 1'b0;
    reset  = 1'b0;
    chk_on = 1'b0;
    wait_settle("xfer");
    check("done_seen", 32'(done_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    passes        = 0;
    total         = 0;
    cyc           = -100;
    chk_on        = 1'b0;
    busy_end      = 0;
    chk_hi        = 0;
    reset         = 1'b1;
    start         = 1'b0;
    base          = 16'h0000;
    bus.mem_grant = 1'b0;
    bus.mem_rdata = 16'h0000;
    @(posedge clk);
    @(negedge clk);
`ifndef PALETTE_LOADER_CLEAR_EN
    check("rst_busy", 32'(busy), 32'd0);
`endif
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_re", 32'(bus.mem_re), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_pal_cea", 32'(bus.pal_cea), 32'd0);
    check("rst_pal_ada", 32'(bus.pal_ada), 32'd0);
    check("rst_pal_din", 32'(bus.pal_din), 32'd0);
`ifdef PALETTE_LOADER_CLEAR_EN
    push_clear();
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
`ifdef PALETTE_LOADER_CLEAR_EN
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    base  = 16'h4321;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_settle("clear");
`endif
    repeat (2) @(posedge clk);
    #1;
    run_xfer(16'h1000, 0, -1, -1);
    run_xfer(16'h1000, 1, -1, -1);
    run_xfer(16'hFFF0, 0, -1, -1);
    run_xfer(16'h2222, 0, 20, -1);
    run_xfer(16'h3333, 0, -1, 30);
    run_xfer(16'h1000, 0, -1, -1);
    run_xfer(16'h5A5A, 0, -2, -1);
    for (int i = 0; i < 4; i++)
      run_xfer(16'($urandom), 2, -1, -1);
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/palette_loader.md
# palette_loader

Copies the 64-entry colour palette from CPU data memory into the colour palette BRAM (SDPB, 64×16, write port A). A one-cycle `start` pulse from the video timing block at the start of vertical blanking triggers the copy, so the pixel pipeline reads a stable palette for the whole visible frame. The block shares the data-memory read port with the CPU through a grant handshake and streams at most one word per cycle.

## Interface
- `COUNT`, 64: words per transfer; equals palette depth.
- `MEM_AW`, 16: data-memory word-address width.
- `clk` in 1: single clock. Drives the loader and BRAM port A.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request. Ignored while `busy`.
- `base` in MEM_AW: source word address. Sampled on an accepted `start`.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse when the transfer completes.
- `mem_re` out 1: data-memory read request.
- `mem_addr` out MEM_AW: read address.
- `mem_grant` in 1: arbiter accepts the read in the same cycle.
- `mem_rdata` in 16: read data, valid the cycle after an accepted read.
- `pal_cea` out 1: palette write enable, to BRAM `cea`.
- `pal_ada` out 6: palette write address, to BRAM `ada`.
- `pal_din` out 16: palette write data, to BRAM `din`.

## Operation
- A read is accepted when `mem_re && mem_grant`. Exactly one palette write follows each accepted read, one cycle later: `pal_cea`=1, `pal_din`=`mem_rdata`, `pal_ada`=write index.
- States:
  - IDLE: `start` latches `base` into the address register, clears the read and write counters, and moves to READ.
  - READ: `mem_re`=1 and `mem_addr`=base+rd_cnt. Each accepted read increments rd_cnt. The accepted read with rd_cnt==COUNT-1 moves the FSM to DRAIN.
  - DRAIN: `mem_re`=0. The final write occurs. Moves to DONE.
  - DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- `busy`=1 in READ and DRAIN only.
- Address arithmetic is modulo 2^MEM_AW; base+rd_cnt wraps through 0 with no error. Write index is 6 bits and runs 0..COUNT-1, never wrapping within a transfer.
- `mem_grant` low in READ: `mem_re` and `mem_addr` are held; no write happens the following cycle.
- `start` while busy or in DONE: ignored, with no effect on the latched base.
- `reset` mid-transfer: the next cycle is IDLE, and `pal_cea` is 0 from that cycle on. Palette contents are partially updated; this is acceptable because a full reload happens next frame.
- Reset values: `busy`=0, `done`=0, `mem_re`=0, `mem_addr`=0, `pal_cea`=0, `pal_ada`=0, `pal_din`=0.

## Timing
- All outputs are registered.
- With `mem_grant` held high and `start` at cycle 0:
  - reads at cycles 1..COUNT;
  - writes at cycles 2..COUNT+1;
  - `done` at cycle COUNT+2.
- With COUNT=64, the transfer is 66 cycles, well inside vertical blanking.
- Each grant-low cycle adds one cycle to the total.
- `busy` rises at cycle 1 and falls the cycle `done` is asserted.
- A new `start` is accepted at the earliest the cycle after `done`.

## Configuration
- `PALETTE_LOADER_CLEAR_EN`
  - Defined: after reset, the FSM enters a CLEAR state that writes 0x0000 to palette addresses 0..COUNT-1, one per cycle, with `busy`=1 and `mem_re`=0. It then enters IDLE without pulsing `done`. `start` is ignored during CLEAR. Reset during CLEAR restarts CLEAR at address 0.
  - Undefined: reset goes directly to IDLE and palette contents are untouched.

## Structure
- Shared package `brus16_pkg`:
  - `PAL_DEPTH`=64, `PAL_AW`=6, `WORD_W`=16;
  - loader state enum: IDLE, READ, DRAIN, DONE, plus CLEAR under the macro.
- Single module; no natural sub-module. Counters and the FSM live inline.

## Test plan
- Grant always high, `base`=0x1000, memory word = addr^0xA5A5: 64 writes at consecutive cycles, `pal_ada` 0..63 with `pal_din`=(0x1000+i)^0xA5A5; `done` at cycle 66; `busy` high for cycles 1..65.
- Grant low on every other cycle: same 64 writes with correct data, no duplicates or gaps in `pal_ada`; `done` at cycle 2+127.
- `base`=0xFFF0: reads wrap after 0xFFFF to 0x0000; write 16 takes data from address 0x0000; `done` still follows the 64th write.
- `start` pulsed again at cycle 20 with a different `base`: ignored; all 64 writes use the original base.
- `reset` at cycle 30: `pal_cea`=0 and `busy`=0 from cycle 31; a fresh `start` then performs a full 64-word copy.
- With `PALETTE_LOADER_CLEAR_EN` defined: after reset, 64 writes of 0x0000 to addresses 0..63, no `done` pulse, and a `start` during CLEAR is ignored.
